// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-port round-robin arbiter for a shared byte-wide RAM with a
//             registered read path. Serialises byte reads and writes from
//             port 0 (cpu core) and port 1 (host loader / debug monitor) onto
//             a single RAM port. A per-transfer lock keeps ownership across
//             multi-byte bursts. An unused lock is dropped after LOCK_TIMEOUT
//             idle cycles.
//  Ports    : clk, resetn (async, active low)
//             req/we/addr/wdata/lock (in), ack/rdata (out)  x2 requesters
//             mem_raddr, mem_waddr, mem_data_in, mem_write (out) -> RAM
//             mem_data_out (in) <- RAM registered read data
//             owner, busy (out) status
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 9,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [7:0]            wdata0,
    input  logic                  lock0,
    output logic                  ack0,
    output logic [7:0]            rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [7:0]            wdata1,
    input  logic                  lock1,
    output logic                  ack1,
    output logic [7:0]            rdata1,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [7:0]            mem_data_in,
    output logic                  mem_write,
    input  logic [7:0]            mem_data_out,
    output logic                  owner,
    output logic                  busy
);

    localparam int CNT_W = $clog2(LOCK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD1  = 3'd1,
        S_RD2  = 3'd2,
        S_WR   = 3'd3,
        S_ACK  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_rr_last;
    logic                  r_locked;
    logic [CNT_W-1:0]      r_lock_cnt;

    logic                  w_grant;
    logic                  w_grant_valid;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [7:0]            w_sel_wdata;
    logic                  w_own_lock;

    // Arbitration and next-state decode
    always_comb begin
        w_grant       = 1'b0;
        w_grant_valid = 1'b0;
        if (r_locked) begin
            // Locked: the other port is not even looked at
            w_grant       = owner;
            w_grant_valid = owner ? req1 : req0;
        end else if (req0 && req1) begin
            w_grant       = ~r_rr_last;
            w_grant_valid = 1'b1;
        end else if (req0 || req1) begin
            w_grant       = req1;
            w_grant_valid = 1'b1;
        end

        w_sel_we    = w_grant ? we1    : we0;
        w_sel_addr  = w_grant ? addr1  : addr0;
        w_sel_wdata = w_grant ? wdata1 : wdata0;
        w_own_lock  = owner   ? lock1  : lock0;

        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_valid) w_next = w_sel_we ? S_WR : S_RD1;
            S_RD1:   w_next = S_RD2;
            S_RD2:   w_next = S_ACK;
            S_WR:    w_next = S_ACK;
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Registered outputs and arbitration bookkeeping
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            mem_raddr   <= '0;
            mem_waddr   <= '0;
            mem_data_in <= '0;
            mem_write   <= 1'b0;
            owner       <= 1'b0;
            r_rr_last   <= 1'b1;     // port 0 wins the first tie
            r_locked    <= 1'b0;
            r_lock_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        owner      <= w_grant;
                        r_rr_last  <= w_grant;
                        r_lock_cnt <= '0;
                        if (w_sel_we) begin
                            mem_waddr   <= w_sel_addr;
                            mem_data_in <= w_sel_wdata;
                            mem_write   <= 1'b1;
                        end else begin
                            mem_raddr   <= w_sel_addr;
                        end
                    end else if (r_locked) begin
                        // Owner is holding the lock but not using it
                        if (r_lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            r_locked   <= 1'b0;
                            r_lock_cnt <= '0;
                        end else begin
                            r_lock_cnt <= r_lock_cnt + 1'b1;
                        end
                    end
                end
                S_RD2: begin
                    // RAM data for the address issued at grant is valid now
                    if (owner) begin
                        rdata1 <= mem_data_out;
                        ack1   <= 1'b1;
                    end else begin
                        rdata0 <= mem_data_out;
                        ack0   <= 1'b1;
                    end
                end
                S_WR: begin
                    mem_write <= 1'b0;
                    if (owner) ack1 <= 1'b1;
                    else       ack0 <= 1'b1;
                end
                S_ACK: begin
                    // lock is sampled while the requester still shows the
                    // command that is being acknowledged
                    ack0       <= 1'b0;
                    ack1       <= 1'b0;
                    r_locked   <= w_own_lock;
                    r_lock_cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire
